// File: rtl/clk_div_pkg.sv
// Shared defaults, channel operation encoding and sizing helper for clk_div_prog.
package clk_div_pkg;

  localparam int unsigned DefClkHz = 50_000_000;
  localparam int unsigned DefCntW  = 32;
  // One-second half-period at the default board clock.
  localparam int unsigned DefHalf  = DefClkHz;

  // What a channel does on the coming clock edge.
  typedef enum logic [1:0] {
    ChRun  = 2'd0,
    ChTerm = 2'd1,
    ChHold = 2'd2,
    ChSync = 2'd3
  } chan_op_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow half-period, 50 % square wave and edge tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned DEF_HALF = DefHalf
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_val_i,
  output logic             clko_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] ResetHalf = (DEF_HALF == 0) ? CNT_W'(1) : CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clko_q, clko_d;
  logic             tick_q, tick_d;
  logic             terminal;
  logic             apply;
  chan_op_e         op;

  assign terminal = (cnt_q == half_q - CNT_W'(1));

  always_comb begin
    if (sync_i)       op = ChSync;
    else if (!en_i)   op = ChHold;
    else if (terminal) op = ChTerm;
    else              op = ChRun;
  end

  always_comb begin
    cnt_d     = cnt_q;
    half_d    = half_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clko_d    = clko_q;
    tick_d    = 1'b0;
    apply     = 1'b0;
    unique case (op)
      ChRun: cnt_d = cnt_q + CNT_W'(1);
      ChTerm: begin
        cnt_d  = '0;
        clko_d = ~clko_q;
        tick_d = 1'b1;
        apply  = pending_q;
      end
      ChHold, ChSync: begin
        cnt_d  = '0;
        clko_d = 1'b0;
        apply  = pending_q;
      end
      default: ;
    endcase
    // Only a write already pending before this edge is applied; a new write waits.
    if (apply) begin
      half_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_i) begin
      shadow_d  = (wr_val_i == '0) ? CNT_W'(1) : wr_val_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      half_q    <= ResetHalf;
      shadow_q  <= ResetHalf;
      pending_q <= 1'b0;
      clko_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clko_q    <= clko_d;
      tick_q    <= tick_d;
    end
  end

  assign clko_o = clko_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Define CLKDIV_SYNC_EN to add the global sync input that re-phases all channels.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DefClkHz,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned DEF_HALF = CLK_HZ
) (
  input  logic                      clki,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            en,
  input  logic                      div_wr,
  input  logic [sel_width(NCH)-1:0] div_sel,
  input  logic [CNT_W-1:0]          div_val,
`ifdef CLKDIV_SYNC_EN
  input  logic                      sync,
`endif
  output logic                      div_ack,
  output logic [NCH-1:0]            clko,
  output logic [NCH-1:0]            tick
);

  logic sel_ok;
  logic sync_all;
  logic div_ack_q;

  assign sel_ok = (32'(div_sel) < NCH);

`ifdef CLKDIV_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      div_ack_q <= 1'b0;
    end else begin
      div_ack_q <= div_wr && sel_ok;
    end
  end

  assign div_ack = div_ack_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic wr_hit;
    assign wr_hit = div_wr && sel_ok && (32'(div_sel) == 32'(i));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clki     (clki),
      .rst_n    (rst_n),
      .en_i     (en[i]),
      .sync_i   (sync_all),
      .wr_i     (wr_hit),
      .wr_val_i (div_val),
      .clko_o   (clko[i]),
      .tick_o   (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: an absolute-time toggle schedule predicts clko/tick/div_ack.
module tb_clk_div_prog;

  localparam int unsigned NCH      = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DEF_HALF = 4;
  localparam int unsigned SELW     = 2;

  logic             clki = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic             div_wr = 1'b0;
  logic [SELW-1:0]  div_sel = '0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_ack;
  logic [NCH-1:0]   clko;
  logic [NCH-1:0]   tick;
`ifdef CLKDIV_SYNC_EN
  logic             sync = 1'b0;
`endif

  always #5 clki = ~clki;

  clk_div_prog #(
    .CLK_HZ   (1000),
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) dut (
    .clki    (clki),
    .rst_n   (rst_n),
    .en      (en),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .div_ack (div_ack),
    .clko    (clko),
    .tick    (tick)
  );

  typedef struct packed {
    logic [NCH-1:0] clko;
    logic [NCH-1:0] tick;
    logic           ack;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference: each running channel has an absolute edge number for its next toggle.
  int unsigned m_half[NCH];
  int unsigned m_shadow[NCH];
  bit          m_pend[NCH];
  bit          m_lvl[NCH];
  bit          m_run[NCH];
  longint      m_next[NCH];
  longint      edge_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_half[c]   = DEF_HALF;
      m_shadow[c] = DEF_HALF;
      m_pend[c]   = 1'b0;
      m_lvl[c]    = 1'b0;
      m_run[c]    = 1'b0;
      m_next[c]   = 0;
    end
    edge_n = 0;
  endfunction

  function automatic exp_t model_step(input logic [NCH-1:0] en_v, input logic wr,
                                      input logic [SELW-1:0] sel, input logic [CNT_W-1:0] val);
    exp_t r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!en_v[c]) begin
        m_lvl[c] = 1'b0;
        m_run[c] = 1'b0;
        if (m_pend[c]) begin
          m_half[c] = m_shadow[c];
          m_pend[c] = 1'b0;
        end
      end else begin
        if (!m_run[c]) begin
          m_run[c]  = 1'b1;
          m_next[c] = edge_n + longint'(m_half[c]) - 1;
        end
        if (edge_n == m_next[c]) begin
          m_lvl[c]  = ~m_lvl[c];
          r.tick[c] = 1'b1;
          if (m_pend[c]) begin
            m_half[c] = m_shadow[c];
            m_pend[c] = 1'b0;
          end
          m_next[c] = edge_n + longint'(m_half[c]);
        end
      end
      r.clko[c] = m_lvl[c];
    end
    if (wr && (int'(sel) < NCH)) begin
      m_shadow[sel] = (val == 0) ? 1 : int'(val);
      m_pend[sel]   = 1'b1;
      r.ack         = 1'b1;
    end
    edge_n++;
    return r;
  endfunction

  task automatic drive(input logic [NCH-1:0] en_v, input logic wr,
                       input logic [SELW-1:0] sel, input logic [CNT_W-1:0] val);
    en      = en_v;
    div_wr  = wr;
    div_sel = sel;
    div_val = val;
    @(posedge clki);
    #1;
    q.push_back(model_step(en_v, wr, sel, val));
  endtask

  task automatic idle(input logic [NCH-1:0] en_v, input int n);
    for (int k = 0; k < n; k++) drive(en_v, 1'b0, '0, '0);
  endtask

  // Monitor: compares every presented output cycle against the oldest expectation.
  always @(negedge clki) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clko", 32'(clko), 32'(e.clko));
      chk("tick", 32'(tick), 32'(e.tick));
      chk("div_ack", 32'(div_ack), 32'(e.ack));
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 8) begin
      @(negedge clki);
      guard++;
    end
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [NCH-1:0] en_r;
    int             guard;
    model_reset();
    repeat (3) @(negedge clki);
    chk("reset_clko", 32'(clko), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_ack", 32'(div_ack), 32'd0);
    rst_n = 1'b1;

    // Default half-period: rises on edge 4, falls on 8, ticks 4/8/12.
    idle('1, 14);
    // Divisor change mid-period, zero divisor, invalid select, back-to-back overwrite.
    drive('1, 1'b1, 2'd1, 16'd2);
    idle('1, 10);
    drive('1, 1'b1, 2'd0, 16'd0);
    idle('1, 10);
    drive('1, 1'b1, 2'd3, 16'd5);
    drive('1, 1'b1, 2'd2, 16'd7);
    drive('1, 1'b1, 2'd2, 16'd3);
    idle('1, 16);
    // Drop en[2] while running, then re-enable.
    idle(3'b011, 3);
    idle('1, 12);

    en_r = '1;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 39) == 0) en_r[c] = ~en_r[c];
      if ($urandom_range(0, 7) == 0)
        drive(en_r, 1'b1, SELW'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 6)));
      else
        drive(en_r, 1'b0, '0, '0);
    end

    // Async reset with clko high and a write pending on channel 1.
    drive('1, 1'b1, 2'd0, 16'd5);
    idle('1, 1);
    drive('1, 1'b1, 2'd1, 16'd6);
    guard = 0;
    while (!m_lvl[0] && guard < 20) begin
      idle('1, 1);
      guard++;
    end
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clko", 32'(clko), 32'd0);
    chk("async_reset_tick", 32'(tick), 32'd0);
    chk("async_reset_ack", 32'(div_ack), 32'd0);
    @(negedge clki);
    rst_n = 1'b1;
    model_reset();
    idle('1, 20);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Parametrised multi-channel programmable clock divider; successor to the fixed single-output 0.5 Hz toggler. Each of NCH channels divides the system clock by a runtime-programmable half-period and produces a 50 % duty square wave plus a one-cycle tick strobe. Divisor updates use a write/ack handshake and take effect only on a period boundary, so outputs never glitch. Sits between the board clock and slow consumers: blinkers, display scan, debouncers.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; documentation and default derivation only.
- NCH, 4, number of independent output channels (≥1).
- CNT_W, 32, counter and divisor width.
- DEF_HALF, 50_000_000, reset half-period in clki cycles for every channel (1 s high / 1 s low).
- clki  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- en  in  NCH  per-channel run enable.
- div_wr  in  1  divisor write strobe, one cycle.
- div_sel  in  max(1,$clog2(NCH))  target channel for div_wr.
- div_val  in  CNT_W  new half-period in cycles.
- div_ack  out  1  one-cycle acknowledge of an accepted write.
- clko  out  NCH  divided clocks.
- tick  out  NCH  one-cycle pulse, coincident with every clko edge.
- sync  in  1  present only with CLKDIV_SYNC_EN.

## Operation
- Reset (async, rst_n=0): cnt=0, clko=0, tick=0, div_ack=0, half_act=shadow=DEF_HALF, pending=0 on all channels.
- Per channel, en=1: each clki edge cnt increments; when cnt==half_act-1: cnt<=0, clko<=~clko, tick<=1 for that cycle; otherwise tick<=0. Output period = 2·half_act cycles.
- en=0: next edge cnt<=0, clko<=0, tick<=0; held. Re-enable restarts from cnt=0; first toggle (clko 0→1) on the half_act-th enabled edge.
- Write: div_wr=1 with div_sel<NCH → shadow[div_sel]<=div_val, pending<=1, div_ack=1 on next cycle. div_sel≥NCH: ignored, no ack.
- div_val==0 is stored as 1 (toggle every cycle).
- Apply: at a terminal cycle (cnt==half_act-1) with pending=1 already set → half_act<=shadow, pending<=0. Write landing on the same cycle as the terminal is not applied until the following terminal.
- Disabled channel with pending=1: half_act<=shadow on next edge.
- Second write before apply: shadow overwritten; only last value applied.
- Arithmetic: counter is CNT_W bits unsigned; never exceeds half_act-1.

## Timing
- div_wr → div_ack: 1 cycle, registered; back-to-back writes each acked.
- clko and tick are registered and change on the same edge.
- Reset mid-operation: outputs 0 immediately (async), pending update discarded.
- No combinational path from inputs to outputs.

## Configuration
- CLKDIV_SYNC_EN defined: adds input sync; sync=1 on an edge clears cnt and clko to 0 in all channels and applies any pending shadow; tick=0 that cycle; sync has priority over terminal count and en.
- Undefined: no sync port; channels phase-free relative to each other.

## Structure
- Shared package clk_div_pkg: DEF_HALF default, CNT_W default, channel-state encoding constants.
- Sub-module clk_div_chan: one channel (cnt, half_act, shadow, pending, clko, tick); top instantiates NCH copies via generate and holds write decode and div_ack.

## Test plan
- DEF_HALF=4, en=1 after reset release → clko rises on edge 4, falls on edge 8, tick pulses on edges 4, 8, 12.
- Ch1 at cnt=1, write div_val=2 → div_ack next cycle; current 4-cycle half completes, then clko period 4.
- Write div_val=0 to ch0 → after next terminal, clko toggles every cycle, tick stays 1.
- en[2] dropped at cnt=2 with clko=1 → clko=0 next edge; re-enable → first rise after 4 edges.
- rst_n low mid-period with pending write → clko=0 immediately; after release period back to DEF_HALF=4.
- CLKDIV_SYNC_EN: ch0 half=3, ch1 half=5 out of phase, sync pulse → both clko=0, cnt=0; ch0 rises 3 edges later, ch1 5 edges later.
